// File: rtl/part_init_bridge.sv
// Initiator-side partition bridge: snapshots mission-clock edges into tagged
// outbound vectors, then freezes that mission clock until the target replies.
module part_init_bridge #(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 9,
   parameter int WDOG_MAX = 10000,
   parameter int CH_W     = $clog2(N_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_CH-1:0]          clk_h_i,
   input  logic                     put_en_i,
   input  logic                     get_en_i,
   input  logic [N_CH*DATA_W-1:0]   sut_data_i,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [CH_W-1:0]          tx_ch_o,
   output logic [DATA_W-1:0]        tx_data_o,
   input  logic                     rx_valid_i,
   input  logic [CH_W-1:0]          rx_ch_i,
   input  logic [DATA_W-1:0]        rx_data_i,
   output logic                     rx_ready_o,
   output logic [N_CH-1:0]          freeze_clk_o,
   output logic [N_CH-1:0]          rcv_valid_o,
   output logic [N_CH*DATA_W-1:0]   rcv_data_o,
   output logic [N_CH-1:0]          ovf_o,
   output logic                     wdog_err_o
);
   localparam int CNT_W = $clog2(WDOG_MAX) + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, ERR} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [N_CH-1:0]       clk_h_q;
   logic [N_CH-1:0]       edges;
   logic [N_CH-1:0]       pending;
   logic [N_CH-1:0]       ovf;
   logic [N_CH-1:0]       sel_onehot;
   logic [N_CH-1:0]       cur_onehot;
   logic [N_CH-1:0]       rcv_valid;
   logic [N_CH*DATA_W-1:0] rcv_data;
   logic [CH_W-1:0]       sel_ch;
   logic [CH_W-1:0]       cur_ch;
   logic [DATA_W-1:0]     snap;
   logic [CNT_W-1:0]      cnt;
   logic                  sel_any;
   logic                  take;
   logic                  accept;
   logic                  wdog_hit;
   logic                  wdog_err;

   assign edges      = clk_h_i & ~clk_h_q;
   assign sel_onehot = N_CH'(1) << sel_ch;
   assign cur_onehot = N_CH'(1) << cur_ch;

   // Lowest-index pending channel wins arbitration
   always_comb begin
      sel_any = 1'b0;
      sel_ch  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (pending[i] && !sel_any) begin
            sel_any = 1'b1;
            sel_ch  = CH_W'(i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      take         = 1'b0;
      accept       = 1'b0;
      wdog_hit     = 1'b0;
      tx_valid_o   = 1'b0;
      rx_ready_o   = 1'b0;
      freeze_clk_o = '0;
      case (state)
         IDLE: begin
            if (sel_any) begin
               take = 1'b1;
               if (put_en_i)      state_nxt = SEND;
               else if (get_en_i) state_nxt = WAIT;
            end
         end
         SEND: begin
            tx_valid_o = 1'b1;
            if (tx_ready_i) state_nxt = get_en_i ? WAIT : IDLE;
         end
         WAIT: begin
            freeze_clk_o = cur_onehot;
            rx_ready_o   = (rx_ch_i == cur_ch);
            accept       = rx_valid_i & rx_ready_o;
            if (accept) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_W'(WDOG_MAX - 1)) begin
               wdog_hit  = 1'b1;
               state_nxt = ERR;
            end
         end
         ERR: begin
            freeze_clk_o = cur_onehot;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_h_q   <= '0;
         pending   <= '0;
         ovf       <= '0;
         cur_ch    <= '0;
         snap      <= '0;
         cnt       <= '0;
         rcv_valid <= '0;
         rcv_data  <= '0;
         wdog_err  <= 1'b0;
      end else begin
         clk_h_q   <= clk_h_i;
         // A new edge re-arms the bit even if it is being taken this cycle
         pending   <= (pending & ~(take ? sel_onehot : '0)) | edges;
         ovf       <= ovf | (edges & pending);
         if (take) begin
            cur_ch <= sel_ch;
            snap   <= sut_data_i[int'(sel_ch)*DATA_W +: DATA_W];
         end
         rcv_valid <= accept ? cur_onehot : '0;
         if (accept) rcv_data[int'(cur_ch)*DATA_W +: DATA_W] <= rx_data_i;
         cnt       <= (state == WAIT && !accept) ? cnt + 1'b1 : '0;
         if (wdog_hit) wdog_err <= 1'b1;
      end
   end

   assign tx_ch_o     = (state == SEND) ? cur_ch : '0;
   assign tx_data_o   = (state == SEND) ? snap : '0;
   assign rcv_valid_o = rcv_valid;
   assign rcv_data_o  = rcv_data;
   assign ovf_o       = ovf;
   assign wdog_err_o  = wdog_err;
endmodule
